sd_block_sequencer: RTL and testbench

- Hardware command sequencer that sits directly upstream of sdc_controller on its 7-bit register bus (addr/we/data_in/data_out).
- Turns a single-block request (CMD17 read or CMD24 write, 32-bit block address) into the full register-programming sequence, then polls status until transfer-complete, error or timeout.
- When idle it passes the spi_link_sm register bus straight through, so host pokes still work.
- The FIFO data path is untouched; the block only drives the register bus.

---
 rtl/sd_seq_pkg.sv | 37 +++
 rtl/sd_seq_rom.sv | 45 ++++
 rtl/sd_block_sequencer.sv | 154 +++++++++++++++
 tb/tb_sd_block_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_seq_pkg.sv
// rtl/sd_seq_pkg.sv - shared types and register map for the SD block sequencer
//
// Holds the sequencer state encoding, the sdc_controller register addresses
// touched by the programming sequence, and the command / command-setting
// byte values for single-block read (CMD17) and write (CMD24).
package sd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PROGRAM,
    POLL_ERR,
    POLL_ERR_S,
    POLL_STS,
    POLL_STS_S,
    CLEAR,
    DONE
  } seq_state_e;

  localparam logic [6:0] REG_ARG0    = 7'h00;
  localparam logic [6:0] REG_ARG1    = 7'h01;
  localparam logic [6:0] REG_ARG2    = 7'h02;
  localparam logic [6:0] REG_ARG3    = 7'h03;
  localparam logic [6:0] REG_CMDSET  = 7'h04;
  localparam logic [6:0] REG_CMD     = 7'h05;
  localparam logic [6:0] REG_BLKSZ_L = 7'h44;
  localparam logic [6:0] REG_BLKSZ_H = 7'h45;
  localparam logic [6:0] REG_BLKCNT  = 7'h48;

  localparam logic [7:0] CMD17       = 8'd17;
  localparam logic [7:0] CMD24       = 8'd24;
  localparam logic [7:0] CMDSET_RD   = 8'h7D;
  localparam logic [7:0] CMDSET_WR   = 8'h80;

  // Step index of the ARG0 write, which launches the command.
  localparam logic [3:0] LAST_STEP   = 4'd10;

endpackage

// File: rtl/sd_seq_rom.sv
// rtl/sd_seq_rom.sv - register programming table for one block command
//
// Purely combinational. Maps a step index plus the latched request onto the
// register address and byte to write at that step.
//   step      in  4   programming step, 0..10
//   req_write in  1   1 = CMD24 write, 0 = CMD17 read
//   blk       in  32  block address (command argument)
//   addr      out 7   register address for this step
//   data      out 8   byte to write at this step
module sd_seq_rom
  import sd_seq_pkg::*;
#(
  parameter int         BLKSIZE     = 512,
  parameter logic [6:0] STATUS_ADDR = 7'h30,
  parameter logic [6:0] ERR_ADDR    = 7'h32
) (
  input  logic [3:0]  step,
  input  logic        req_write,
  input  logic [31:0] blk,
  output logic [6:0]  addr,
  output logic [7:0]  data
);

  localparam logic [15:0] BLK_LEN = 16'(BLKSIZE - 1);

  always_comb begin
    addr = REG_ARG0;
    data = 8'h00;
    case (step)
      4'd0:  begin addr = STATUS_ADDR; data = 8'hFF;                          end
      4'd1:  begin addr = ERR_ADDR;    data = 8'hFF;                          end
      4'd2:  begin addr = REG_BLKCNT;  data = 8'h00;                          end
      4'd3:  begin addr = REG_BLKSZ_L; data = BLK_LEN[7:0];                   end
      4'd4:  begin addr = REG_BLKSZ_H; data = BLK_LEN[15:8];                  end
      4'd5:  begin addr = REG_CMD;     data = req_write ? CMD24 : CMD17;      end
      4'd6:  begin addr = REG_CMDSET;  data = req_write ? CMDSET_WR : CMDSET_RD; end
      4'd7:  begin addr = REG_ARG3;    data = blk[31:24];                     end
      4'd8:  begin addr = REG_ARG2;    data = blk[23:16];                     end
      4'd9:  begin addr = REG_ARG1;    data = blk[15:8];                      end
      4'd10: begin addr = REG_ARG0;    data = blk[7:0];                       end
      default: begin addr = REG_ARG0;  data = 8'h00;                          end
    endcase
  end

endmodule

// File: rtl/sd_block_sequencer.sv
// rtl/sd_block_sequencer.sv - single-block command sequencer in front of sdc_controller
//
// Accepts one CMD17/CMD24 request, programs the controller registers, polls
// error/status until transfer-complete, error or timeout, clears both status
// registers and pulses done. In IDLE the host register bus passes straight
// through to the controller.
//   clk, rstn        clock, synchronous active-low reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_write        1 = CMD24 write, 0 = CMD17 read
//   req_blk          32-bit block address
//   done, err        one-cycle completion pulse and its error flag
//   busy             high outside IDLE
//   host_addr/we/data  register bus from spi_link_sm
//   sd_addr/we/data_o  register bus to sdc_controller
//   sd_data_i        read data from sdc_controller (1-cycle latency)
module sd_block_sequencer
  import sd_seq_pkg::*;
#(
  parameter int          BLKSIZE        = 512,
  parameter logic [6:0]  STATUS_ADDR    = 7'h30,
  parameter logic [6:0]  ERR_ADDR       = 7'h32,
  parameter int          DONE_BIT       = 1,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_blk,
  output logic        done,
  output logic        err,
  output logic        busy,
  input  logic [6:0]  host_addr,
  input  logic        host_we,
  input  logic [7:0]  host_data,
  output logic [6:0]  sd_addr,
  output logic        sd_we,
  output logic [7:0]  sd_data_o,
  input  logic [7:0]  sd_data_i
);

  seq_state_e  state, state_d;
  logic [3:0]  step;
  logic [23:0] tmo_cnt;
  logic        wr_q;
  logic [31:0] blk_q;
  logic        err_flag;
  logic        fail_d;
  logic        polling;
  logic        tmo_hit;
  logic [6:0]  rom_addr;
  logic [7:0]  rom_data;

  sd_seq_rom #(
    .BLKSIZE     (BLKSIZE),
    .STATUS_ADDR (STATUS_ADDR),
    .ERR_ADDR    (ERR_ADDR)
  ) u_rom (
    .step      (step),
    .req_write (wr_q),
    .blk       (blk_q),
    .addr      (rom_addr),
    .data      (rom_data)
  );

  assign polling = (state inside {POLL_ERR, POLL_ERR_S, POLL_STS, POLL_STS_S});
  assign tmo_hit = polling && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == DONE) && err_flag;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      step     <= 4'd0;
      tmo_cnt  <= 24'd0;
      wr_q     <= 1'b0;
      blk_q    <= 32'd0;
      err_flag <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && req_valid) begin
        wr_q  <= req_write;
        blk_q <= req_blk;
      end
      // The step counter also sequences the two CLEAR writes; it is zero
      // on entry to CLEAR because every polling state holds it at zero.
      step    <= (state == PROGRAM || state == CLEAR) ? step + 4'd1 : 4'd0;
      tmo_cnt <= polling ? tmo_cnt + 24'd1 : 24'd0;
      if (state != CLEAR && state_d == CLEAR) begin
        err_flag <= fail_d;
      end
    end
  end

  always_comb begin
    state_d   = state;
    fail_d    = 1'b0;
    sd_addr   = host_addr;
    sd_data_o = host_data;
    sd_we     = 1'b0;
    case (state)
      IDLE: begin
        sd_we = host_we;
        if (req_valid) state_d = PROGRAM;
      end
      PROGRAM: begin
        sd_addr   = rom_addr;
        sd_data_o = rom_data;
        sd_we     = 1'b1;
        if (step == LAST_STEP) state_d = POLL_ERR;
      end
      POLL_ERR: begin
        sd_addr = ERR_ADDR;
        fail_d  = 1'b1;
        state_d = tmo_hit ? CLEAR : POLL_ERR_S;
      end
      POLL_ERR_S: begin
        sd_addr = ERR_ADDR;
        fail_d  = 1'b1;
        if (tmo_hit || sd_data_i != 8'h00) state_d = CLEAR;
        else                               state_d = POLL_STS;
      end
      POLL_STS: begin
        sd_addr = STATUS_ADDR;
        fail_d  = 1'b1;
        state_d = tmo_hit ? CLEAR : POLL_STS_S;
      end
      POLL_STS_S: begin
        sd_addr = STATUS_ADDR;
        // Timeout wins over a status hit landing in the same cycle.
        fail_d  = tmo_hit;
        if (tmo_hit || sd_data_i[DONE_BIT]) state_d = CLEAR;
        else                                state_d = POLL_ERR;
      end
      CLEAR: begin
        sd_addr   = step[0] ? ERR_ADDR : STATUS_ADDR;
        sd_data_o = 8'hFF;
        sd_we     = 1'b1;
        if (step[0]) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_block_sequencer.sv
// tb/tb_sd_block_sequencer.sv - self-checking bench for sd_block_sequencer
module tb_sd_block_sequencer;

  localparam int         TMO    = 1000;
  localparam logic [6:0] STS_A  = 7'h30;
  localparam logic [6:0] ERR_A  = 7'h32;
  localparam logic [15:0] BSZ_M1 = 16'd511;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_blk;
  logic        done, err, busy;
  logic [6:0]  host_addr;
  logic        host_we;
  logic [7:0]  host_data;
  logic [6:0]  sd_addr;
  logic        sd_we;
  logic [7:0]  sd_data_o;
  logic [7:0]  sd_data_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  sd_block_sequencer #(.TIMEOUT_CYCLES(24'd1000)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_blk(req_blk),
    .done(done), .err(err), .busy(busy),
    .host_addr(host_addr), .host_we(host_we), .host_data(host_data),
    .sd_addr(sd_addr), .sd_we(sd_we), .sd_data_o(sd_data_o), .sd_data_i(sd_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller register model: W1C status/error, 1-cycle read latency.
  // mode 0: never completes, 1: status bit 1 sets dly cycles after launch,
  // 2: error register reads 0x04 right after launch.
  logic [7:0] regs [128];
  logic [7:0] m_sts, m_err;
  int m_mode, m_dly, m_launch;
  bit m_armed;

  always @(posedge clk) begin
    if (!rstn) begin
      m_sts <= 8'h00; m_err <= 8'h00; m_armed <= 1'b0;
    end else begin
      if (sd_we) begin
        if (sd_addr == STS_A)      m_sts <= m_sts & ~sd_data_o;
        else if (sd_addr == ERR_A) m_err <= m_err & ~sd_data_o;
        else                       regs[sd_addr] <= sd_data_o;
        if (sd_addr == 7'h00) begin
          m_launch <= cyc;
          m_armed  <= (m_mode == 1);
          if (m_mode == 2) m_err <= m_err | 8'h04;
        end
      end else if (m_armed && cyc + 1 >= m_launch + m_dly) begin
        m_sts   <= m_sts | 8'h02;
        m_armed <= 1'b0;
      end
    end
    sd_data_i <= (sd_addr == STS_A) ? m_sts : (sd_addr == ERR_A) ? m_err : regs[sd_addr];
  end

  typedef struct { int c; logic [6:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];
  int done_cnt = 0;
  int sts_reads = 0;

  always @(negedge clk) begin
    if (busy && sd_we) wlog.push_back('{cyc, sd_addr, sd_data_o});
    if (done) done_cnt <= done_cnt + 1;
    if (busy && !sd_we && sd_addr == STS_A) sts_reads <= sts_reads + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input bit wr, input logic [31:0] blk, input int mode, input int dly, input bit poke);
    int acc_c, l_c, dc, n, base, sbase, k, s, exp_dc;
    bit got_done, derr, exp_err;
    logic [6:0] ea [13];
    logic [7:0] ed [13];
    m_mode = mode; m_dly = dly;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("ready_before_req", 64'(req_ready), 64'd1);
    if (!req_ready) return;
    base = wlog.size(); sbase = sts_reads;
    req_valid = 1'b1; req_write = wr; req_blk = blk;
    acc_c = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_blk = $urandom;
    check("busy_rise", 64'(busy), 64'd1);
    check("ready_low", 64'(req_ready), 64'd0);
    got_done = 1'b0; n = 0; dc = 0; derr = 1'b0;
    while (!got_done && n < TMO + 200) begin
      if (done) begin
        got_done = 1'b1; dc = cyc; derr = err;
      end else begin
        if (poke && cyc == acc_c + 60) begin
          host_addr = 7'h24; host_data = 8'h5A; host_we = 1'b1;
          req_valid = 1'b1; req_write = ~wr;
          #1;
          check("busy_host_drop", 64'(sd_we), 64'd0);
          check("busy_not_ready", 64'(req_ready), 64'd0);
        end
        if (poke && cyc == acc_c + 63) begin
          host_we = 1'b0; req_valid = 1'b0;
        end
        @(negedge clk); n++;
      end
    end
    check("done_seen", 64'(got_done), 64'd1);
    if (!got_done) return;
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("ready_after_done", 64'(req_ready), 64'd1);

    l_c = acc_c + 11;
    if (mode == 2) begin
      exp_dc = l_c + 5; exp_err = 1'b1;
      check("err_no_sts_poll", 64'(sts_reads - sbase), 64'd0);
    end else if (mode == 0) begin
      exp_dc = l_c + TMO + 3; exp_err = 1'b1;
    end else begin
      // Status reads are presented at l_c+3+4k and sampled one cycle later.
      k = (dly > 3) ? (dly - 3 + 3) / 4 : 0;
      s = l_c + 3 + 4 * k + 1;
      if (s >= l_c + TMO) begin exp_dc = l_c + TMO + 3; exp_err = 1'b1; end
      else begin exp_dc = s + 3; exp_err = 1'b0; end
    end
    check("done_cycle", 64'(dc), 64'(exp_dc));
    check("done_err", 64'(derr), 64'(exp_err));

    ea = '{STS_A, ERR_A, 7'h48, 7'h44, 7'h45, 7'h05, 7'h04, 7'h03, 7'h02, 7'h01, 7'h00, STS_A, ERR_A};
    ed = '{8'hFF, 8'hFF, 8'h00, BSZ_M1[7:0], BSZ_M1[15:8], wr ? 8'd24 : 8'd17, wr ? 8'h80 : 8'h7D,
           blk[31:24], blk[23:16], blk[15:8], blk[7:0], 8'hFF, 8'hFF};
    check("write_count", 64'(wlog.size() - base), 64'd13);
    for (int i = 0; i < 13; i++) begin
      if (base + i < wlog.size()) begin
        check($sformatf("wr%0d_addr", i), 64'(wlog[base + i].a), 64'(ea[i]));
        check($sformatf("wr%0d_data", i), 64'(wlog[base + i].d), 64'(ed[i]));
        check($sformatf("wr%0d_cycle", i), 64'(wlog[base + i].c),
              64'((i < 11) ? acc_c + 1 + i : exp_dc - 13 + i));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc, base, dbase;
    bit wr;
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_blk = 32'd0;
    host_addr = 7'd0; host_we = 1'b0; host_data = 8'd0;
    m_mode = 0; m_dly = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    host_addr = 7'h24; host_data = 8'h00; host_we = 1'b1;
    #1;
    check("bypass_addr", 64'(sd_addr), 64'h24);
    check("bypass_we", 64'(sd_we), 64'd1);
    check("bypass_data", 64'(sd_data_o), 64'h00);
    @(negedge clk);
    host_we = 1'b0;

    run_req(1'b0, 32'h0000_0123, 1, 30, 1'b0);
    run_req(1'b1, 32'h0000_0000, 1, 200, 1'b1);
    run_req(1'b0, $urandom, 2, 0, 1'b0);
    run_req(1'b1, $urandom, 0, 0, 1'b0);
    run_req(1'b0, $urandom, 1, 997, 1'b0);

    // Reset during PROGRAM step 5 abandons the sequence.
    base = wlog.size(); dbase = done_cnt;
    m_mode = 1; m_dly = 10;
    req_valid = 1'b1; req_write = 1'b1; req_blk = 32'hDEAD_BEEF;
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < acc + 6) @(negedge clk);
    check("rst_mid_step5", 64'(sd_addr), 64'h05);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    host_we = 1'b1; host_addr = 7'h24; host_data = 8'h11;
    #1;
    check("rst_mid_bypass_we", 64'(sd_we), 64'd1);
    check("rst_mid_bypass_addr", 64'(sd_addr), 64'h24);
    host_we = 1'b0; rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_no_done", 64'(done_cnt), 64'(dbase));
    check("rst_mid_no_clear", 64'(wlog.size()), 64'(base + 6));
    run_req(1'b0, $urandom, 1, $urandom_range(3, 80), 1'b0);

    for (int r = 0; r < 6; r++) begin
      wr = 1'($urandom_range(0, 1));
      run_req(wr, $urandom, $urandom_range(1, 2), $urandom_range(3, 80), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
